// File: rtl/return_addr_stack.sv
// return_addr_stack: return-address stack for the 5-stage MIPS front end.
// Records link addresses on jal, predicts the jr target one cycle after the
// pop, and checks the EX-resolved jr target against that prediction, raising
// a one-cycle mispredict/redirect to the PC mux.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall             ID stalled; push/pop ignored this cycle
//   flush             drop pending prediction and suppress any resolve
//   push_valid/pc     jal decoded in ID, PC of the jal
//   pop_valid         jr decoded in ID
//   resolve_valid/addr  jr in EX with its actual target
//   pred_valid/addr   registered prediction
//   mispredict        one-cycle redirect pulse, target on redirect_addr
//   count             live entries, 0..DEPTH
//
// Optional feature macro: RAS_STATS_EN adds 16-bit saturating counters
// stat_hits, stat_miss and stat_ovf.
module return_addr_stack #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned PTR_W    = 3,
  parameter int unsigned LINK_OFS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             push_valid,
  input  logic [31:0]      push_pc,
  input  logic             pop_valid,
  input  logic             resolve_valid,
  input  logic [31:0]      resolve_addr,
  output logic             pred_valid,
  output logic [31:0]      pred_addr,
  output logic             mispredict,
  output logic [31:0]      redirect_addr,
  output logic [PTR_W:0]   count
`ifdef RAS_STATS_EN
  ,
  output logic [15:0]      stat_hits,
  output logic [15:0]      stat_miss,
  output logic [15:0]      stat_ovf
`endif
);

  localparam logic [PTR_W:0] FullCnt = (PTR_W + 1)'(DEPTH);

  logic [31:0]      stack_q [DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             pred_valid_q, pred_valid_d;
  logic [31:0]      pred_addr_q, pred_addr_d;
  logic             pending_valid_q, pending_valid_d;
  logic [31:0]      pending_addr_q, pending_addr_d;
  logic             mispredict_q, mispredict_d;
  logic [31:0]      redirect_addr_q, redirect_addr_d;

  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [31:0]      link_addr;
  logic [31:0]      pred_next;
  logic             do_push, do_pop, empty, full, miss;

  always_comb begin
    do_push   = push_valid & ~stall;
    do_pop    = pop_valid & ~stall;
    empty     = (count_q == '0);
    full      = (count_q == FullCnt);
    link_addr = push_pc + 32'(LINK_OFS);
    pred_next = empty ? 32'h0 : stack_q[top_q];
    miss      = ~pending_valid_q | (pending_addr_q != resolve_addr);

    top_d           = top_q;
    count_d         = count_q;
    wr_en           = 1'b0;
    wr_idx          = top_q;
    pred_valid_d    = pred_valid_q;
    pred_addr_d     = pred_addr_q;
    pending_valid_d = pending_valid_q;
    pending_addr_d  = pending_addr_q;
    mispredict_d    = 1'b0;
    redirect_addr_d = redirect_addr_q;

    // Stack update and prediction.
    if (do_pop && do_push) begin
      // Replace the top in place; an empty stack gains its first entry.
      wr_en  = 1'b1;
      wr_idx = top_q;
      if (empty) count_d = count_q + 1'b1;
    end else if (do_pop) begin
      if (!empty) begin
        top_d   = top_q - 1'b1;
        count_d = count_q - 1'b1;
      end
    end else if (do_push) begin
      // When full, top+1 is the oldest entry and gets overwritten.
      wr_en  = 1'b1;
      wr_idx = top_q + 1'b1;
      top_d  = top_q + 1'b1;
      if (!full) count_d = count_q + 1'b1;
    end

    if (!stall) begin
      pred_valid_d = pop_valid & ~empty;
      if (pop_valid) pred_addr_d = pred_next;
    end

    // Resolution uses the old pending value before a same-cycle pop reloads it.
    if (resolve_valid) begin
      mispredict_d    = miss;
      pending_valid_d = 1'b0;
      if (miss) redirect_addr_d = resolve_addr;
    end

    if (do_pop) begin
      pending_valid_d = 1'b1;
      pending_addr_d  = pred_next;
    end

    if (flush) begin
      pending_valid_d = 1'b0;
      pred_valid_d    = 1'b0;
      pred_addr_d     = pred_addr_q;
      mispredict_d    = 1'b0;
      redirect_addr_d = redirect_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_q           <= '0;
      count_q         <= '0;
      pred_valid_q    <= 1'b0;
      pred_addr_q     <= '0;
      pending_valid_q <= 1'b0;
      pending_addr_q  <= '0;
      mispredict_q    <= 1'b0;
      redirect_addr_q <= '0;
    end else begin
      top_q           <= top_d;
      count_q         <= count_d;
      pred_valid_q    <= pred_valid_d;
      pred_addr_q     <= pred_addr_d;
      pending_valid_q <= pending_valid_d;
      pending_addr_q  <= pending_addr_d;
      mispredict_q    <= mispredict_d;
      redirect_addr_q <= redirect_addr_d;
    end
  end

  // Storage is not reset; entries beyond count are never read as valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) stack_q[wr_idx] <= link_addr;
  end

  assign pred_valid    = pred_valid_q;
  assign pred_addr     = pred_addr_q;
  assign mispredict    = mispredict_q;
  assign redirect_addr = redirect_addr_q;
  assign count         = count_q;

`ifdef RAS_STATS_EN
  logic [15:0] stat_hits_q, stat_hits_d;
  logic [15:0] stat_miss_q, stat_miss_d;
  logic [15:0] stat_ovf_q, stat_ovf_d;

  always_comb begin
    stat_hits_d = stat_hits_q;
    stat_miss_d = stat_miss_q;
    stat_ovf_d  = stat_ovf_q;
    if (resolve_valid && !flush) begin
      if (miss) begin
        if (stat_miss_q != 16'hffff) stat_miss_d = stat_miss_q + 16'd1;
      end else begin
        if (stat_hits_q != 16'hffff) stat_hits_d = stat_hits_q + 16'd1;
      end
    end
    // Only a plain push while full overwrites an entry.
    if (do_push && !do_pop && full && stat_ovf_q != 16'hffff) stat_ovf_d = stat_ovf_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits_q <= '0;
      stat_miss_q <= '0;
      stat_ovf_q  <= '0;
    end else begin
      stat_hits_q <= stat_hits_d;
      stat_miss_q <= stat_miss_d;
      stat_ovf_q  <= stat_ovf_d;
    end
  end

  assign stat_hits = stat_hits_q;
  assign stat_miss = stat_miss_q;
  assign stat_ovf  = stat_ovf_q;
`endif

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed bench for return_addr_stack: a behavioural list-based stack and
// pending-jr model computes the expected outputs of each cycle, queues them
// in a scoreboard when the stimulus is driven, and they are popped and
// compared after the clock edge that produces them.
module tb_return_addr_stack;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PTR_W = 3;

  logic             clk = 1'b0;
  logic             rst, stall, flush, push_valid, pop_valid, resolve_valid;
  logic [31:0]      push_pc, resolve_addr;
  logic             pred_valid, mispredict;
  logic [31:0]      pred_addr, redirect_addr;
  logic [PTR_W:0]   count;

  return_addr_stack #(
    .DEPTH   (DEPTH),
    .PTR_W   (PTR_W),
    .LINK_OFS(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .push_valid   (push_valid),
    .push_pc      (push_pc),
    .pop_valid    (pop_valid),
    .resolve_valid(resolve_valid),
    .resolve_addr (resolve_addr),
    .pred_valid   (pred_valid),
    .pred_addr    (pred_addr),
    .mispredict   (mispredict),
    .redirect_addr(redirect_addr),
    .count        (count)
`ifdef RAS_STATS_EN
    ,
    .stat_hits    (),
    .stat_miss    (),
    .stat_ovf     ()
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        pv;
    logic [31:0] pa;
    bit          chk_pa;
    logic        mp;
    logic [31:0] ra;
    int unsigned cnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_stk[$];
  logic        m_pv, m_pend_v;
  logic [31:0] m_pa, m_pend_a, m_ra;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input string what, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s.%s observed=%h expected=%h", tag, what, got, exp);
  endtask

  // One clock of stimulus; model predicts the post-edge outputs.
  task automatic cyc(input string tag, input bit psh, input logic [31:0] pc, input bit pp,
                     input bit rv, input logic [31:0] raddr, input bit fl, input bit st);
    exp_t        e;
    exp_t        got_e;
    logic [31:0] link;
    logic [31:0] pn;
    bit          emp;
    link = pc + 32'd4;
    emp  = (m_stk.size() == 0);
    pn   = emp ? 32'h0 : m_stk[m_stk.size() - 1];
    e.tag = tag;
    e.mp  = 1'b0;
    if (rv && !fl) begin
      e.mp = !m_pend_v || (m_pend_a != raddr);
      if (e.mp) m_ra = raddr;
      m_pend_v = 1'b0;
    end
    if (!st) begin
      if (pp && !fl) begin
        m_pend_v = 1'b1;
        m_pend_a = pn;
        m_pa     = pn;
      end
      m_pv = pp && !emp;
      if (pp && psh) begin
        if (emp) m_stk.push_back(link);
        else m_stk[m_stk.size() - 1] = link;
      end else if (pp) begin
        if (!emp) void'(m_stk.pop_back());
      end else if (psh) begin
        m_stk.push_back(link);
        if (m_stk.size() > DEPTH) void'(m_stk.pop_front());
      end
    end
    if (fl) begin
      m_pv     = 1'b0;
      m_pend_v = 1'b0;
    end
    e.pv     = m_pv;
    e.pa     = m_pa;
    e.chk_pa = pp && !st && !fl;
    e.ra     = m_ra;
    e.cnt    = m_stk.size();
    sb.push_back(e);

    push_valid    = psh;
    push_pc       = pc;
    pop_valid     = pp;
    resolve_valid = rv;
    resolve_addr  = raddr;
    flush         = fl;
    stall         = st;
    @(posedge clk);
    #1;
    push_valid    = 1'b0;
    pop_valid     = 1'b0;
    resolve_valid = 1'b0;
    flush         = 1'b0;
    stall         = 1'b0;

    got_e = sb.pop_front();
    chk(got_e.tag, "pred_valid", 32'(pred_valid), 32'(got_e.pv));
    if (got_e.chk_pa) chk(got_e.tag, "pred_addr", pred_addr, got_e.pa);
    chk(got_e.tag, "mispredict", 32'(mispredict), 32'(got_e.mp));
    if (got_e.mp) chk(got_e.tag, "redirect_addr", redirect_addr, got_e.ra);
    chk(got_e.tag, "count", 32'(count), got_e.cnt);
  endtask

  task automatic push(input string tag, input logic [31:0] pc);
    cyc(tag, 1'b1, pc, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic pop(input string tag);
    cyc(tag, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input string tag, input logic [31:0] a);
    cyc(tag, 1'b0, 32'h0, 1'b0, 1'b1, a, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; push_valid = 1'b0; pop_valid = 1'b0;
    resolve_valid = 1'b0; push_pc = '0; resolve_addr = '0;
    m_stk.delete();
    m_pv = 1'b0; m_pa = '0; m_pend_v = 1'b0; m_pend_a = '0; m_ra = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset", "pred_valid", 32'(pred_valid), 32'd0);
    chk("reset", "pred_addr", pred_addr, 32'h0);
    chk("reset", "mispredict", 32'(mispredict), 32'd0);
    chk("reset", "redirect_addr", redirect_addr, 32'h0);
    chk("reset", "count", 32'(count), 32'd0);
    rst = 1'b0;

    // Single call/return.
    push("t1_push", 32'h0040_0010);
    chk("t1_push", "count_lit", 32'(count), 32'd1);
    pop("t1_pop");
    chk("t1_pop", "pred_addr_lit", pred_addr, 32'h0040_0014);
    resolve("t1_res", 32'h0040_0014);

    // Nested calls; resolves overlap the following pops.
    push("t2_push0", 32'h100);
    push("t2_push1", 32'h200);
    push("t2_push2", 32'h300);
    pop("t2_pop0");
    chk("t2_pop0", "pred_addr_lit", pred_addr, 32'h304);
    cyc("t2_pop1", 1'b0, 32'h0, 1'b1, 1'b1, 32'h304, 1'b0, 1'b0);
    chk("t2_pop1", "pred_addr_lit", pred_addr, 32'h204);
    cyc("t2_pop2", 1'b0, 32'h0, 1'b1, 1'b1, 32'h204, 1'b0, 1'b0);
    chk("t2_pop2", "pred_addr_lit", pred_addr, 32'h104);
    resolve("t2_res", 32'h104);

    // Empty pop then resolve.
    pop("t3_pop");
    resolve("t3_res", 32'h0040_0020);
    chk("t3_res", "redirect_lit", redirect_addr, 32'h0040_0020);
    cyc("t3_idle", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Overflow: nine pushes into eight entries.
    for (int i = 0; i < 9; i++) push($sformatf("t4_push%0d", i), 32'h1000 + 32'(16 * i));
    chk("t4_full", "count_lit", 32'(count), 32'd8);
    for (int i = 0; i < 9; i++) pop($sformatf("t4_pop%0d", i));

    // Stall holds everything on the ID side.
    cyc("t5_stall", 1'b1, 32'h900, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

    // Simultaneous push/pop replaces top.
    push("t6_push0", 32'h100);
    push("t6_push1", 32'h200);
    cyc("t6_pushpop", 1'b1, 32'h500, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("t6_pushpop", "pred_addr_lit", pred_addr, 32'h204);
    resolve("t6_res", 32'h208);
    pop("t6_pop0");
    chk("t6_pop0", "pred_addr_lit", pred_addr, 32'h504);
    pop("t6_pop1");

    // Flush with a resolve suppresses the redirect and drops the pending jr.
    push("t7_push", 32'h700);
    pop("t7_pop");
    cyc("t7_flush", 1'b0, 32'h0, 1'b0, 1'b1, 32'h704, 1'b1, 1'b0);
    resolve("t7_res", 32'h704);
    cyc("t7_idle", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
- Return-address stack for the 5-stage MIPS pipeline. It is the producer side of jump-register targets: it records link addresses on jal and predicts the jr target at ID. The EX-stage jr address path then resolves the actual target.
- The block checks the resolved jr_addr against its own prediction and raises a one-cycle mispredict/redirect to the PC mux.
- Lets the front end redirect on jr without waiting for EX.

Parameters:
- DEPTH, 8, number of stack entries (power of two).
- PTR_W, 3, log2(DEPTH); pointer width.
- LINK_OFS, 4, byte offset added to the jal PC to form the link address.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous, active-high reset
- stall  input  1  ID stage stalled; push/pop ignored this cycle
- flush  input  1  pipeline flush; drops pending prediction
- push_valid  input  1  jal decoded in ID
- push_pc  input  32  PC of the jal instruction
- pop_valid  input  1  jr decoded in ID
- resolve_valid  input  1  jr in EX, actual target available
- resolve_addr  input  32  forwarded jr target from EX
- pred_valid  output  1  prediction available (registered)
- pred_addr  output  32  predicted jr target
- mispredict  output  1  one-cycle pulse, redirect required
- redirect_addr  output  32  correct target when mispredict=1
- count  output  PTR_W+1  live entries, 0..DEPTH

Behaviour:
- Reset (rst=1 at posedge):
  - pred_valid=0, pred_addr=0, mispredict=0, redirect_addr=0, count=0.
  - top pointer=0, pending_valid=0, pending_addr=0.
  - Stack storage contents are don't-care.
- Storage: circular buffer of DEPTH x 32, indexed by top pointer. The pointer wraps modulo DEPTH.
- Push only (push_valid & ~pop_valid & ~stall):
  - Write push_pc+LINK_OFS (32-bit wrap) at top+1, then top<=top+1.
  - count<=min(count+1, DEPTH).
  - When full, the push overwrites the oldest entry and count stays at DEPTH.
- Pop only (pop_valid & ~push_valid & ~stall):
  - count>0: next cycle pred_valid=1, pred_addr=entry[top]. top<=top-1, count<=count-1.
  - count=0: next cycle pred_valid=0, pred_addr=0. Pointer and count unchanged.
- Simultaneous push & pop (~stall):
  - Prediction is the old top, or invalid if empty.
  - The pushed link then replaces entry[top]. count is unchanged, except empty becomes 1.
- stall=1: push/pop ignored. pred_valid/pred_addr are held; pending_valid/pending_addr are not touched.
- Prediction latency: pop at cycle N gives pred_valid/pred_addr at N+1. On the same edge, pending_valid<=1 and pending_addr<=prediction (pending_addr=0 when invalid).
- Only one jr can be in flight between ID and EX, so a single pending register suffices.
- Resolution at cycle M (resolve_valid=1):
  - At M+1, mispredict=1 when ~pending_valid, or pending_addr != resolve_addr. On mispredict, redirect_addr=resolve_addr.
  - Otherwise mispredict=0.
  - pending_valid<=0 in both cases.
  - mispredict is always a single-cycle pulse.
- Resolve and pop in the same cycle: resolution uses the old pending value; the pop loads the new one.
- resolve_valid with no pending entry (after flush): counts as a mispredict.
- flush=1: pending_valid<=0 and pred_valid<=0. Stack contents and count are kept.
  - flush has priority over a simultaneous pop's pending load.
  - A resolve in the same cycle is suppressed, so mispredict=0.
- rst mid-operation: all state is cleared at that edge, and any in-flight mispredict is suppressed.

Optional Feature:
- Macro: RAS_STATS_EN.
- Defined: adds three 16-bit saturating outputs, all cleared by rst:
  - stat_hits: resolves with mispredict=0.
  - stat_miss: resolves with mispredict=1.
  - stat_ovf: pushes that occur while full.
- Undefined: these ports and counters do not exist; no other behaviour changes.

Test Plan:
- Reset, push_pc=0x00400010, then pop → pred_addr=0x00400014 at N+1, count 1→0. Resolve 0x00400014 → mispredict=0.
- Nested: push 0x100, 0x200, 0x300; pop three times → preds 0x304, 0x204, 0x104 in order, count=0.
- Empty pop then resolve 0x00400020 → pred_valid=0, mispredict=1, redirect_addr=0x00400020.
- Overflow at DEPTH=8: push 9 links (0x1000+16i, i=0..8) → count=8. 8 pops return 0x1084 down to 0x1014; 9th pop gives pred_valid=0.
- Simultaneous push 0x500 / pop with top=0x204 → pred 0x204, new top 0x504, count unchanged. Wrong resolve 0x208 → mispredict=1, redirect_addr=0x208.
- Pop, then flush together with a resolve → mispredict=0, pending cleared. A later resolve without a pop → mispredict=1.
